// File: rtl/pipe_stage_skid_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_pkg
//
// Shared definitions for the pipeline stage registers that sit between
// IF/ID/EX/MEM/WB.
//   - Occupancy state encoding (EMPTY / ONE / FULL) and its enum type.
//   - Bit positions of the write-back control fields packed into i_ctrl.
//   - Per-boundary payload/control widths.
//   - Small helpers to pack and inspect the write-back control word.
// ---------------------------------------------------------------------------
package pipe_stage_skid_pkg;

    // Occupancy encoding. The value doubles as the entry count so the
    // o_count output is a direct copy of the state register.
    localparam logic [1:0] ST_EMPTY_ENC = 2'd0;
    localparam logic [1:0] ST_ONE_ENC   = 2'd1;
    localparam logic [1:0] ST_FULL_ENC  = 2'd2;

    typedef enum logic [1:0] {
        EMPTY = ST_EMPTY_ENC,
        ONE   = ST_ONE_ENC,
        FULL  = ST_FULL_ENC
    } state_t;

    // Write-back control word layout (MSB first: JAL, MemToReg, RegWrite,
    // TamanoFiltroL[1:0], ZeroExtend, LUI).
    localparam int CTRL_LUI      = 0;
    localparam int CTRL_ZEXT     = 1;
    localparam int CTRL_TFL_LO   = 2;
    localparam int CTRL_TFL_HI   = 3;
    localparam int CTRL_REGWRITE = 4;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_JAL      = 6;
    localparam int WB_CTRL_W     = 7;

    // Per-boundary widths. A 32-bit word per datapath field plus the 5-bit
    // destination register index.
    localparam int WORD_W        = 32;
    localparam int REG_IDX_W     = 5;
    localparam int IF_ID_DATA_W  = 2 * WORD_W;                 // PC4, Instruction
    localparam int ID_EX_DATA_W  = 4 * WORD_W + REG_IDX_W;     // PC4, PC8, Instr, Ext, Rd
    localparam int EX_MEM_DATA_W = 5 * WORD_W + REG_IDX_W;     // + ALU
    localparam int MEM_WB_DATA_W = 6 * WORD_W + REG_IDX_W;     // + DatoMemoria = 197

    localparam int IF_ID_CTRL_W  = WB_CTRL_W;
    localparam int ID_EX_CTRL_W  = WB_CTRL_W;
    localparam int EX_MEM_CTRL_W = WB_CTRL_W;
    localparam int MEM_WB_CTRL_W = WB_CTRL_W;

    // Pack the individual write-back control signals into one word.
    function automatic logic [WB_CTRL_W-1:0] pack_wb_ctrl(
        input logic       jal,
        input logic       mem_to_reg,
        input logic       reg_write,
        input logic [1:0] tamano_filtro_l,
        input logic       zero_extend,
        input logic       lui
    );
        logic [WB_CTRL_W-1:0] w_word;
        w_word                            = '0;
        w_word[CTRL_JAL]                  = jal;
        w_word[CTRL_MEMTOREG]             = mem_to_reg;
        w_word[CTRL_REGWRITE]             = reg_write;
        w_word[CTRL_TFL_HI:CTRL_TFL_LO]   = tamano_filtro_l;
        w_word[CTRL_ZEXT]                 = zero_extend;
        w_word[CTRL_LUI]                  = lui;
        return w_word;
    endfunction

    // True when the control word has any architectural side effect in WB.
    function automatic logic wb_has_side_effect(input logic [WB_CTRL_W-1:0] ctrl);
        return ctrl[CTRL_REGWRITE] | ctrl[CTRL_MEMTOREG] | ctrl[CTRL_JAL];
    endfunction

endpackage : pipe_stage_skid_pkg

// File: rtl/pipe_slot.sv
// ---------------------------------------------------------------------------
// pipe_slot
//
// One storage entry of a pipeline stage: a payload register and a control
// register, both updated on the falling edge of i_clk.
//
// Ports
//   i_clk       clock (state changes on the falling edge)
//   i_reset     asynchronous active-high reset, clears payload and control
//   i_load      capture i_data / i_ctrl
//   i_clr_ctrl  zero the control register, payload holds (bubble insert)
//   i_data      payload in
//   i_ctrl      control in
//   o_data      stored payload
//   o_ctrl      stored control
// ---------------------------------------------------------------------------
module pipe_slot #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 7
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic              i_clr_ctrl,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    // A control clear wins over a load: the payload is left untouched so a
    // killed entry keeps its last datapath value while becoming a bubble.
    always_ff @(negedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_data <= '0;
            r_ctrl <= '0;
        end else if (i_clr_ctrl) begin
            r_ctrl <= '0;
        end else if (i_load) begin
            r_data <= i_data;
            r_ctrl <= i_ctrl;
        end
    end

    assign o_data = r_data;
    assign o_ctrl = r_ctrl;

endmodule : pipe_slot

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//
// Pipeline stage register with a valid/ready handshake. With SKID=1 a second
// entry absorbs the beat that arrives in the cycle downstream stalls, so
// o_ready is a pure decode of registered state. With SKID=0 the stage is a
// single register whose ready follows downstream combinationally.
//
// Ports
//   i_clk        clock, all state updates on the falling edge
//   i_reset      asynchronous active-high reset
//   i_valid      upstream entry valid
//   o_ready      stage can accept this cycle
//   i_data       upstream payload
//   i_ctrl       upstream control
//   o_valid      head entry valid
//   i_ready      downstream accepts the head
//   o_data       head payload (not gated, holds last main value)
//   o_ctrl       head control, 0 when o_valid is 0
//   i_flush      kill all entries, next state EMPTY
//   i_clr_cnt    clear the stall counter
//   o_stall_cnt  saturating count of cycles with o_valid & !i_ready
//   o_count      occupancy 0..2
// ---------------------------------------------------------------------------
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int DATA_W = MEM_WB_DATA_W,
    parameter int CTRL_W = MEM_WB_CTRL_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    input  logic              i_flush,
    input  logic              i_clr_cnt,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [1:0]        o_count
);

    state_t            r_state;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_valid;
    logic              w_accept;
    logic              w_drain;
    logic              w_stall;
    logic              w_main_load;
    logic              w_main_from_skid;

    logic [DATA_W-1:0] w_main_d_data;
    logic [CTRL_W-1:0] w_main_d_ctrl;
    logic [DATA_W-1:0] w_main_q_data;
    logic [CTRL_W-1:0] w_main_q_ctrl;
    logic [DATA_W-1:0] w_skid_q_data;
    logic [CTRL_W-1:0] w_skid_q_ctrl;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign w_valid  = (r_state != EMPTY);
    assign w_accept = i_valid & o_ready & ~i_flush;
    assign w_drain  = w_valid & i_ready;
    assign w_stall  = w_valid & ~i_ready;

    generate
        if (SKID != 0) begin : g_ready_skid
            // Registered-state decode only: downstream ready never reaches
            // upstream through this stage.
            assign o_ready = (r_state != FULL);
        end else begin : g_ready_reg
            assign o_ready = ~w_valid | i_ready;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Storage: main is always the head; skid only ever refills main, so
    // entries leave in arrival order.
    // ------------------------------------------------------------------
    assign w_main_from_skid = (r_state == FULL);
    assign w_main_load      = ((r_state == EMPTY) & w_accept)
                            | ((r_state == ONE)   & w_accept & w_drain)
                            | ((r_state == FULL)  & w_drain  & ~i_flush);
    assign w_main_d_data    = w_main_from_skid ? w_skid_q_data : i_data;
    assign w_main_d_ctrl    = w_main_from_skid ? w_skid_q_ctrl : i_ctrl;

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_main_load),
        .i_clr_ctrl (i_flush),
        .i_data     (w_main_d_data),
        .i_ctrl     (w_main_d_ctrl),
        .o_data     (w_main_q_data),
        .o_ctrl     (w_main_q_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic w_skid_load;

            // The only way into skid: a beat arrives while the head stalls.
            assign w_skid_load = (r_state == ONE) & w_accept & ~w_drain;

            pipe_slot #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .i_clk      (i_clk),
                .i_reset    (i_reset),
                .i_load     (w_skid_load),
                .i_clr_ctrl (i_flush),
                .i_data     (i_data),
                .i_ctrl     (i_ctrl),
                .o_data     (w_skid_q_data),
                .o_ctrl     (w_skid_q_ctrl)
            );
        end else begin : g_no_skid
            assign w_skid_q_data = '0;
            assign w_skid_q_ctrl = '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Occupancy state machine. Flush overrides every other transition.
    // ------------------------------------------------------------------
    always_ff @(negedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= EMPTY;
        end else if (i_flush) begin
            r_state <= EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_state <= ONE;
                    end
                end
                ONE: begin
                    if (w_accept & ~w_drain & (SKID != 0)) begin
                        r_state <= FULL;
                    end else if (~w_accept & w_drain) begin
                        r_state <= EMPTY;
                    end
                end
                FULL: begin
                    if (w_drain) begin
                        r_state <= ONE;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stall counter: saturating, clear wins, flush leaves it alone.
    // ------------------------------------------------------------------
    always_ff @(negedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
        end else if (i_clr_cnt) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_valid     = w_valid;
    assign o_data      = w_main_q_data;
    // A bubble must never present RegWrite/MemToReg downstream.
    assign o_ctrl      = w_valid ? w_main_q_ctrl : '0;
    assign o_stall_cnt = r_stall_cnt;
    assign o_count     = r_state;

endmodule : pipe_stage_skid

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Two instances share the clock and reset: index 0 is the skid variant
// (SKID=1), index 1 the single-register variant (SKID=0); both use a 4-bit
// stall counter. Each has its own stimulus and its own FIFO model of the
// stage (entry list, head payload, stall count).
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;
    import pipe_stage_skid_pkg::*;

    localparam int DW = 16;
    localparam int CW = WB_CTRL_W;
    localparam int NW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic          tv[2];
    logic [DW-1:0] td[2];
    logic [CW-1:0] tc[2];
    logic          tr[2];
    logic          tf[2];
    logic          tk[2];

    logic          orr[2];
    logic          ov[2];
    logic [DW-1:0] od[2];
    logic [CW-1:0] oc[2];
    logic [NW-1:0] os[2];
    logic [1:0]    on[2];

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) u_skid (
        .i_clk(clk), .i_reset(rst), .i_valid(tv[0]), .o_ready(orr[0]),
        .i_data(td[0]), .i_ctrl(tc[0]), .o_valid(ov[0]), .i_ready(tr[0]),
        .o_data(od[0]), .o_ctrl(oc[0]), .i_flush(tf[0]), .i_clr_cnt(tk[0]),
        .o_stall_cnt(os[0]), .o_count(on[0])
    );

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(NW)) u_reg (
        .i_clk(clk), .i_reset(rst), .i_valid(tv[1]), .o_ready(orr[1]),
        .i_data(td[1]), .i_ctrl(tc[1]), .o_valid(ov[1]), .i_ready(tr[1]),
        .o_data(od[1]), .o_ctrl(oc[1]), .i_flush(tf[1]), .i_clr_cnt(tk[1]),
        .o_stall_cnt(os[1]), .o_count(on[1])
    );

    // ---------------- reference model ----------------
    int               m_n[2];        // entries held
    logic [CW+DW-1:0] m_ent[2][2];   // {ctrl, data}, index 0 is the head
    logic [DW-1:0]    m_main[2];     // last payload that reached the head
    int               m_cnt[2];

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
    endtask

    function automatic logic m_rdy(input int d);
        if (d == 0) return (m_n[d] < 2);
        return (m_n[d] == 0) || tr[d];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_n[d] = 0; m_main[d] = '0; m_cnt[d] = 0;
        end
    endtask

    task automatic model_step(input int d);
        bit v, acc, drn;
        v   = (m_n[d] > 0);
        acc = tv[d] && m_rdy(d) && !tf[d];
        drn = v && tr[d];
        if (tk[d]) m_cnt[d] = 0;
        else if (v && !tr[d] && m_cnt[d] < 15) m_cnt[d] = m_cnt[d] + 1;
        if (tf[d]) begin
            m_n[d] = 0;
        end else begin
            if (drn) begin
                m_ent[d][0] = m_ent[d][1];
                m_n[d] = m_n[d] - 1;
            end
            if (acc) begin
                m_ent[d][m_n[d]] = {tc[d], td[d]};
                m_n[d] = m_n[d] + 1;
            end
            if (m_n[d] > 0) m_main[d] = m_ent[d][0][DW-1:0];
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    // ---------------- per-cycle comparison ----------------
    always @(posedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < 2; d++) begin
                chk("valid", d, 32'(ov[d]), 32'(m_n[d] > 0));
                chk("ready", d, 32'(orr[d]), 32'(m_rdy(d)));
                chk("data", d, 32'(od[d]), 32'(m_main[d]));
                chk("ctrl", d, 32'(oc[d]), (m_n[d] > 0) ? 32'(m_ent[d][0][CW+DW-1:DW]) : 32'd0);
                chk("stall_cnt", d, 32'(os[d]), 32'(m_cnt[d]));
                chk("count", d, 32'(on[d]), 32'(m_n[d]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int sent, guard, exp_next;
        bit acc;
        for (int d = 0; d < 2; d++) begin
            tv[d] = 0; td[d] = '0; tc[d] = '0; tr[d] = 0; tf[d] = 0; tk[d] = 0;
        end
        model_reset();
        #1 rst = 1'b1;
        #11 rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", d, 32'(ov[d]), 0);
            chk("rst_ready", d, 32'(orr[d]), 1);
            chk("rst_data", d, 32'(od[d]), 0);
            chk("rst_ctrl", d, 32'(oc[d]), 0);
            chk("rst_cnt", d, 32'(os[d]), 0);
            chk("rst_count", d, 32'(on[d]), 0);
        end
        cmp_en = 1'b1;

        // 1) stream 8 beats, one edge latency, no stalls
        tr[0] = 1;
        for (int i = 1; i <= 8; i++) begin
            tv[0] = 1; td[0] = DW'(i); tc[0] = CW'(i);
            cyc();
            chk("stream_data", 0, 32'(od[0]), 32'(i));
            chk("stream_valid", 0, 32'(ov[0]), 1);
            chk("stream_count_le1", 0, 32'(on[0] <= 2'd1), 1);
            chk("stream_cnt", 0, 32'(os[0]), 0);
        end
        tv[0] = 0;
        cyc();

        // 2) stall on FULL: A, B accepted, C held
        tr[0] = 0; tv[0] = 1; tc[0] = 7'h10;
        td[0] = 16'h00A1; cyc();
        td[0] = 16'h00B2; cyc();
        chk("full_count", 0, 32'(on[0]), 2);
        chk("full_ready", 0, 32'(orr[0]), 0);
        td[0] = 16'h00C3; cyc();
        chk("full_hold_data", 0, 32'(od[0]), 32'h00A1);
        chk("full_hold_count", 0, 32'(on[0]), 2);
        chk("full_stall_cnt", 0, 32'(os[0]), 2);
        tr[0] = 1; cyc();
        chk("order_b", 0, 32'(od[0]), 32'h00B2);
        chk("ready_back", 0, 32'(orr[0]), 1);
        cyc();
        chk("order_c", 0, 32'(od[0]), 32'h00C3);
        tv[0] = 0; cyc();
        chk("drained_valid", 0, 32'(ov[0]), 0);
        chk("stall_total", 0, 32'(os[0]), 2);

        // 3) flush in FULL with a RegWrite beat presented
        tr[0] = 0; tv[0] = 1; tc[0] = pack_wb_ctrl(0, 0, 1, 2'b00, 0, 0);
        td[0] = 16'h0011; cyc();
        td[0] = 16'h0012; cyc();
        td[0] = 16'h0013; tf[0] = 1; cyc();
        chk("flush_valid", 0, 32'(ov[0]), 0);
        chk("flush_ctrl", 0, 32'(oc[0]), 0);
        chk("flush_count", 0, 32'(on[0]), 0);
        chk("flush_data_hold", 0, 32'(od[0]), 32'h0011);
        tf[0] = 0; tv[0] = 0; tr[0] = 1;
        cyc(); cyc();
        chk("flush_no_ghost", 0, 32'(ov[0]), 0);

        // 4) saturation and clear
        tk[0] = 1; cyc();
        chk("clr_cnt", 0, 32'(os[0]), 0);
        tk[0] = 0; tr[0] = 0; tv[0] = 1; td[0] = 16'h0044; tc[0] = 7'h7f; cyc();
        tv[0] = 0;
        repeat (20) cyc();
        chk("sat_cnt", 0, 32'(os[0]), 15);
        tk[0] = 1; cyc();
        chk("sat_clr", 0, 32'(os[0]), 0);
        tk[0] = 0; cyc();
        chk("sat_restart", 0, 32'(os[0]), 1);
        tr[0] = 1; cyc();

        // 5) randomized traffic on the skid variant
        for (int i = 0; i < 300; i++) begin
            tv[0] = 1'($urandom_range(0, 1));
            tr[0] = ($urandom_range(0, 3) != 0);
            tf[0] = ($urandom_range(0, 19) == 0);
            tk[0] = ($urandom_range(0, 29) == 0);
            td[0] = DW'($urandom);
            tc[0] = CW'($urandom);
            cyc();
        end
        tv[0] = 0; tf[0] = 0; tk[0] = 0; tr[0] = 1;
        cyc(); cyc();

        // 6) SKID=0 with i_ready toggling, source holds each beat until taken
        sent = 0; guard = 0; exp_next = 1;
        while (sent < 16 && guard < 100) begin
            tv[1] = 1; td[1] = DW'(sent + 1); tc[1] = CW'(sent + 1);
            tr[1] = (guard % 2 == 0);
            acc = m_rdy(1);
            if (ov[1] && tr[1]) begin
                chk("skid0_order", 1, 32'(od[1]), 32'(exp_next));
                exp_next++;
            end
            cyc();
            if (acc) sent++;
            guard++;
        end
        chk("skid0_sent", 1, 32'(sent), 16);
        tv[1] = 0; tr[1] = 1;
        for (int i = 0; i < 3; i++) begin
            if (ov[1]) begin
                chk("skid0_order", 1, 32'(od[1]), 32'(exp_next));
                exp_next++;
            end
            cyc();
        end
        chk("skid0_seen", 1, 32'(exp_next - 1), 16);
        chk("skid0_last", 1, 32'(od[1]), 16);

        // 7) asynchronous reset in ONE, checked between edges
        tr[0] = 0; tv[0] = 1; td[0] = 16'h0055; tc[0] = 7'h7f; cyc();
        chk("pre_rst_valid", 0, 32'(ov[0]), 1);
        tv[0] = 0;
        #2 rst = 1'b1;
        #1;
        chk("async_valid", 0, 32'(ov[0]), 0);
        chk("async_ctrl", 0, 32'(oc[0]), 0);
        chk("async_ready", 0, 32'(orr[0]), 1);
        model_reset();
        #3 rst = 1'b0;
        cyc();
        chk("post_rst_count", 0, 32'(on[0]), 0);
        chk("post_rst_ready", 0, 32'(orr[0]), 1);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pipe_stage_skid
